counter_prog_seq: RTL and testbench

Upstream bus-master sequencer for the 8-bit up/down range counter: accepts one configuration request (preload, upper limit, lower limit, cycle count), writes the counter's four registers over its ncs/nwr/nrd/A1/A0/Din bus, optionally reads them back, checks the counter's err flag, issues the start pulse and waits for end-of-cycle. It replaces hand-driven register programming in front of the counter and reports done/fail to the controlling logic.

---
 rtl/counter_prog_pkg.sv | 44 ++++
 rtl/counter_bus_port.sv | 30 +++
 rtl/counter_prog_seq.sv | 202 ++++++++++++++++++++
 tb/tb_counter_prog_seq.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_prog_pkg.sv
// Shared types and constants for the counter programming sequencer and its bus port.
package counter_prog_pkg;

    localparam int DW_DEFAULT = 8;

    // Counter register map on {a1, a0}
    localparam logic [1:0] ADDR_PLR = 2'b00;
    localparam logic [1:0] ADDR_ULR = 2'b01;
    localparam logic [1:0] ADDR_LLR = 2'b10;
    localparam logic [1:0] ADDR_CCR = 2'b11;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_ERR      = 2'b01;
    localparam logic [1:0] FC_READBACK = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    // Write and read states are kept in register-map order so the FSM can step with +1.
    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PLR,
        S_WR_ULR,
        S_WR_LLR,
        S_WR_CCR,
        S_TURN,
        S_RD_PLR,
        S_RD_ULR,
        S_RD_LLR,
        S_RD_CCR,
        S_CHK,
        S_START,
        S_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    // Encoding is the strobe levels {ncs, nwr, nrd}, so the bus pins come straight off flops.
    typedef enum logic [2:0] {
        OP_IDLE = 3'b111,
        OP_SEL  = 3'b011,
        OP_WR   = 3'b001,
        OP_RD   = 3'b010
    } bus_op_t;

endpackage

// File: rtl/counter_bus_port.sv
// Counter bus pin stage: strobes and address from the registered command, tristate Din
// driver, and the read-data path back to the sequencer.
module counter_bus_port
    import counter_prog_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  bus_op_t       op,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] wdata,
    inout  wire  [DW-1:0] Din,
    output logic          ncs,
    output logic          nwr,
    output logic          nrd,
    output logic          a1,
    output logic          a0,
    output logic [DW-1:0] rd_data
);

    logic drive;

    assign {ncs, nwr, nrd} = op;
    assign {a1, a0}        = addr;

    // Only a selected write cycle owns the bus; every other cycle leaves it to the counter.
    assign drive   = !ncs && !nwr;
    assign Din     = drive ? wdata : 'z;
    assign rd_data = Din;

endmodule

// File: rtl/counter_prog_seq.sv
// Bus-master sequencer: programs the counter's four registers, optionally reads them back,
// checks err, fires start and waits for ec, reporting done or a sticky fail code.
module counter_prog_seq
    import counter_prog_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] plr_in,
    input  logic [DW-1:0] ulr_in,
    input  logic [DW-1:0] llr_in,
    input  logic [DW-1:0] ccr_in,
    input  logic          verify_en,
    inout  wire  [DW-1:0] Din,
    output logic          ncs,
    output logic          nwr,
    output logic          nrd,
    output logic          a1,
    output logic          a0,
    output logic          start,
    input  logic          err,
    input  logic          ec,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [1:0]    fail_code
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t             state;
    bus_op_t            op;
    logic [1:0]         addr;
    logic [DW-1:0]      wdata;
    logic [DW-1:0]      rd_data;
    logic [3:0][DW-1:0] regs_q;
    logic               verify_q;
    logic               rd_phase;
    logic [TW-1:0]      tmo_cnt;
    logic               accept;

    assign accept = (state == S_IDLE) && cfg_valid && cfg_ready;

    // NOTE: data-only captures carry no reset; they are always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            regs_q <= {ccr_in, llr_in, ulr_in, plr_in};
        end
    end

    // NOTE: every sequential update uses <= so each branch sees the pre-edge register values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            op        <= OP_IDLE;
            addr      <= ADDR_PLR;
            wdata     <= '0;
            verify_q  <= 1'b0;
            rd_phase  <= 1'b0;
            tmo_cnt   <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            start     <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= FC_NONE;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    cfg_ready <= 1'b1;
                    if (accept) begin
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        fail      <= 1'b0;
                        fail_code <= FC_NONE;
                        verify_q  <= verify_en;
                        op        <= OP_WR;
                        addr      <= ADDR_PLR;
                        wdata     <= plr_in;
                        state     <= S_WR_PLR;
                    end
                end

                S_WR_PLR, S_WR_ULR, S_WR_LLR, S_WR_CCR: begin
                    if (addr == ADDR_CCR) begin
                        if (verify_q) begin
                            op    <= OP_IDLE;
                            state <= S_TURN;
                        end else begin
                            op    <= OP_SEL;
                            state <= S_CHK;
                        end
                    end else begin
                        addr  <= addr + 2'd1;
                        wdata <= regs_q[addr + 2'd1];
                        state <= state_t'(state + 4'd1);
                    end
                end

                S_TURN: begin
                    op       <= OP_RD;
                    addr     <= ADDR_PLR;
                    rd_phase <= 1'b0;
                    state    <= S_RD_PLR;
                end

                // Each read spans two cycles; Din is compared at the edge closing the second.
                S_RD_PLR, S_RD_ULR, S_RD_LLR, S_RD_CCR: begin
                    if (!rd_phase) begin
                        rd_phase <= 1'b1;
                    end else begin
                        rd_phase <= 1'b0;
                        if (rd_data != regs_q[addr]) begin
                            op        <= OP_IDLE;
                            fail      <= 1'b1;
                            fail_code <= FC_READBACK;
                            state     <= S_FAIL;
                        end else if (addr == ADDR_CCR) begin
                            op    <= OP_SEL;
                            state <= S_CHK;
                        end else begin
                            addr  <= addr + 2'd1;
                            state <= state_t'(state + 4'd1);
                        end
                    end
                end

                S_CHK: begin
                    if (err) begin
                        op        <= OP_IDLE;
                        fail      <= 1'b1;
                        fail_code <= FC_ERR;
                        state     <= S_FAIL;
                    end else if (regs_q[ADDR_CCR] == '0) begin
                        op    <= OP_IDLE;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        start <= 1'b1;
                        state <= S_START;
                    end
                end

                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_RUN;
                end

                S_RUN: begin
                    if (ec) begin
                        op    <= OP_IDLE;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (tmo_cnt >= TMO_LAST) begin
                        op        <= OP_IDLE;
                        fail      <= 1'b1;
                        fail_code <= FC_TIMEOUT;
                        state     <= S_FAIL;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                S_DONE, S_FAIL: begin
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    op    <= OP_IDLE;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    counter_bus_port #(
        .DW (DW)
    ) u_bus_port (
        .op      (op),
        .addr    (addr),
        .wdata   (wdata),
        .Din     (Din),
        .ncs     (ncs),
        .nwr     (nwr),
        .nrd     (nrd),
        .a1      (a1),
        .a0      (a0),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_counter_prog_seq.sv
// Directed bench for counter_prog_seq with a small behavioural model of the counter's
// register file, readback driver and err flag.
module tb_counter_prog_seq;

    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [DW-1:0] plr_in    = '0;
    logic [DW-1:0] ulr_in    = '0;
    logic [DW-1:0] llr_in    = '0;
    logic [DW-1:0] ccr_in    = '0;
    logic          verify_en = 1'b0;
    wire  [DW-1:0] Din;
    logic          ncs, nwr, nrd, a1, a0, start;
    logic          err;
    logic          ec        = 1'b0;
    logic          busy, done, fail;
    logic [1:0]    fail_code;

    logic [DW-1:0] mdl_regs [4];
    logic          rd_corrupt = 1'b0;
    logic [1:0]    maddr;
    logic [DW-1:0] rd_value;
    int            start_cnt  = 0;
    int            n_checks   = 0;
    int            n_pass     = 0;

    always #5 clk = ~clk;

    counter_prog_seq #(
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .plr_in    (plr_in),
        .ulr_in    (ulr_in),
        .llr_in    (llr_in),
        .ccr_in    (ccr_in),
        .verify_en (verify_en),
        .Din       (Din),
        .ncs       (ncs),
        .nwr       (nwr),
        .nrd       (nrd),
        .a1        (a1),
        .a0        (a0),
        .start     (start),
        .err       (err),
        .ec        (ec),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_code (fail_code)
    );

    // Counter model: latches writes, answers reads (optionally corrupting ULR to 14), flags bad ranges.
    assign maddr    = {a1, a0};
    assign rd_value = (rd_corrupt && maddr == 2'b01) ? 8'd14 : mdl_regs[maddr];
    assign Din      = (!ncs && !nrd) ? rd_value : 'z;
    assign err      = (mdl_regs[0] > mdl_regs[1]) || (mdl_regs[0] < mdl_regs[2]);

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mdl_regs[i] <= '0;
        end else if (!ncs && !nwr) begin
            mdl_regs[maddr] <= Din;
        end
        if (start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Waits (bounded) for cfg_ready, presents one request for one edge, then scrambles the inputs.
    task automatic start_req(input logic [DW-1:0] p, input logic [DW-1:0] u,
                             input logic [DW-1:0] l, input logic [DW-1:0] c, input logic v);
        int n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", 32'(cfg_ready), 32'd1);
        plr_in    = p;
        ulr_in    = u;
        llr_in    = l;
        ccr_in    = c;
        verify_en = v;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        plr_in    = 8'hA5;
        ulr_in    = 8'h5A;
        llr_in    = 8'hC3;
        ccr_in    = 8'h3C;
        verify_en = ~v;
    endtask

    // Samples cycles 1-4 after accept and checks the four write cycles.
    task automatic check_writes(input string t, input logic [DW-1:0] p, input logic [DW-1:0] u,
                                input logic [DW-1:0] l, input logic [DW-1:0] c);
        logic [DW-1:0] v [4];
        v[0] = p;
        v[1] = u;
        v[2] = l;
        v[3] = c;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("%s_wr%0d_ncs", t, k), 32'(ncs), 32'd0);
            check($sformatf("%s_wr%0d_nwr", t, k), 32'(nwr), 32'd0);
            check($sformatf("%s_wr%0d_nrd", t, k), 32'(nrd), 32'd1);
            check($sformatf("%s_wr%0d_addr", t, k), 32'({a1, a0}), 32'(k));
            check($sformatf("%s_wr%0d_din", t, k), 32'(Din), 32'(v[k]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;

        // Reset values
        @(negedge clk);
        check("rst_ncs", 32'(ncs), 32'd1);
        check("rst_nwr", 32'(nwr), 32'd1);
        check("rst_nrd", 32'(nrd), 32'd1);
        check("rst_addr", 32'({a1, a0}), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_fail_code", 32'(fail_code), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_din_z", 32'(Din === 8'bz), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(cfg_ready), 32'd1);

        // Plain run: writes, CHK, start in cycle 6, done after ec
        s0 = start_cnt;
        start_req(8'd10, 8'd15, 8'd5, 8'd2, 1'b0);
        check_writes("t1", 8'd10, 8'd15, 8'd5, 8'd2);
        @(negedge clk);
        check("t1_chk_ncs", 32'(ncs), 32'd0);
        check("t1_chk_strobes", 32'({nwr, nrd}), 32'b11);
        check("t1_chk_start", 32'(start), 32'd0);
        @(negedge clk);
        check("t1_start_hi", 32'(start), 32'd1);
        check("t1_start_ncs", 32'(ncs), 32'd0);
        @(negedge clk);
        check("t1_run_start_lo", 32'(start), 32'd0);
        check("t1_run_busy", 32'(busy), 32'd1);
        @(negedge clk);
        ec = 1'b1;
        @(negedge clk);
        ec = 1'b0;
        check("t1_done_hi", 32'(done), 32'd1);
        check("t1_done_ncs", 32'(ncs), 32'd1);
        @(negedge clk);
        check("t1_done_lo", 32'(done), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_ready", 32'(cfg_ready), 32'd1);
        check("t1_start_count", 32'(start_cnt - s0), 32'd1);

        // Verify with ULR reading back as 14
        s0 = start_cnt;
        rd_corrupt = 1'b1;
        start_req(8'd10, 8'd15, 8'd5, 8'd2, 1'b1);
        check_writes("t2", 8'd10, 8'd15, 8'd5, 8'd2);
        @(negedge clk);
        check("t2_turn_ncs", 32'(ncs), 32'd1);
        check("t2_turn_din_z", 32'(Din === 8'bz), 32'd1);
        for (int c = 6; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("t2_rd_c%0d_strobes", c), 32'({ncs, nwr, nrd}), 32'b010);
            check($sformatf("t2_rd_c%0d_addr", c), 32'({a1, a0}), 32'((c - 6) / 2));
        end
        @(negedge clk);
        check("t2_fail", 32'(fail), 32'd1);
        check("t2_fail_code", 32'(fail_code), 32'd2);
        check("t2_fail_ncs", 32'(ncs), 32'd1);
        @(negedge clk);
        check("t2_fail_sticky", 32'(fail), 32'd1);
        check("t2_ready", 32'(cfg_ready), 32'd1);
        check("t2_no_start", 32'(start_cnt - s0), 32'd0);
        rd_corrupt = 1'b0;

        // PLR above ULR: counter raises err at CHK
        s0 = start_cnt;
        start_req(8'd20, 8'd15, 8'd5, 8'd2, 1'b0);
        @(negedge clk);
        check("t3_fail_cleared", 32'(fail), 32'd0);
        check("t3_code_cleared", 32'(fail_code), 32'd0);
        repeat (5) @(negedge clk);
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_fail_code", 32'(fail_code), 32'd1);
        check("t3_start_lo", 32'(start), 32'd0);
        @(negedge clk);
        check("t3_no_start", 32'(start_cnt - s0), 32'd0);

        // CCR = 0 without verify: done in cycle 6, no start
        s0 = start_cnt;
        start_req(8'd7, 8'd9, 8'd3, 8'd0, 1'b0);
        check_writes("t4", 8'd7, 8'd9, 8'd3, 8'd0);
        @(negedge clk);
        check("t4_c5_done_lo", 32'(done), 32'd0);
        @(negedge clk);
        check("t4_c6_done_hi", 32'(done), 32'd1);
        check("t4_c6_start_lo", 32'(start), 32'd0);
        @(negedge clk);
        check("t4_c7_done_lo", 32'(done), 32'd0);
        check("t4_no_start", 32'(start_cnt - s0), 32'd0);

        // CCR = 0 with verify: clean readback, CHK in 14, done in 15
        s0 = start_cnt;
        start_req(8'd7, 8'd9, 8'd3, 8'd0, 1'b1);
        repeat (14) @(negedge clk);
        check("t4v_c14_chk", 32'({ncs, nwr, nrd}), 32'b011);
        check("t4v_c14_done_lo", 32'(done), 32'd0);
        @(negedge clk);
        check("t4v_c15_done_hi", 32'(done), 32'd1);
        check("t4v_c15_fail", 32'(fail), 32'd0);
        check("t4v_no_start", 32'(start_cnt - s0), 32'd0);

        // Timeout: RUN entered at edge 6, fail visible from cycle 23
        start_req(8'd10, 8'd15, 8'd5, 8'd2, 1'b0);
        repeat (22) @(negedge clk);
        check("t5_c22_fail_lo", 32'(fail), 32'd0);
        check("t5_c22_ncs", 32'(ncs), 32'd0);
        @(negedge clk);
        check("t5_c23_fail_hi", 32'(fail), 32'd1);
        check("t5_c23_code", 32'(fail_code), 32'd3);
        check("t5_c23_ncs", 32'(ncs), 32'd1);

        // New request clears fail; reset held 3 cycles mid-RUN
        start_req(8'd10, 8'd15, 8'd5, 8'd2, 1'b0);
        @(negedge clk);
        check("t6_fail_cleared", 32'(fail), 32'd0);
        check("t6_code_cleared", 32'(fail_code), 32'd0);
        repeat (7) @(negedge clk);
        check("t6_in_run_ncs", 32'(ncs), 32'd0);
        check("t6_in_run_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_ncs", 32'(ncs), 32'd1);
        check("t6_rst_start", 32'(start), 32'd0);
        check("t6_rst_din_z", 32'(Din === 8'bz), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ready", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_release_ready", 32'(cfg_ready), 32'd1);
        check("t6_release_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
